uart_alu_interface: RTL and testbench

- Responder on the receive end of the TP2 UART link: consumes bytes delivered by the UART receiver, assembles an ALU transaction and returns the ALU result through the UART transmitter.
- Three received bytes make one transaction, in this order: operand A, operand B, opcode.
- Sits between uart_rx/uart_tx and the ALU inside top. The ALU stays a separate, purely combinational block outside this module.

---
 rtl/uart_alu_interface_pkg.sv | 21 ++
 rtl/uart_alu_interface.sv | 74 +++++++
 tb/tb_uart_alu_interface.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_interface_pkg.sv
// uart_alu_interface_pkg: shared widths, ALU opcodes and FSM encoding for the TP2 UART/ALU link
package uart_alu_interface_pkg;
   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;
   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;
endpackage

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B, opcode bytes from uart_rx, drives the ALU, returns its result via uart_tx
//   i_clock/i_reset          clock, synchronous active-high reset
//   i_rx_done_tick/i_rx_data received byte strobe and value
//   i_tx_done_tick           transmitter finished the stop bit
//   i_alu_result             combinational ALU output
//   o_alu_a/o_alu_b/o_alu_op registered ALU operands and opcode
//   o_tx_start/o_tx_data     one-cycle send request and held result byte
//   o_busy/o_overrun         transaction in flight, sticky dropped-byte flag
module uart_alu_interface
   import uart_alu_interface_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_OP   = NB_OP_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx_done_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_tx_done_tick,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_overrun
);
   state_t state, state_next;
   logic   drop;
   // bytes arriving while a result is being produced or sent have nowhere to go
   assign drop       = i_rx_done_tick && (state inside {EXEC, SEND, WAIT_TX});
   assign o_tx_start = state == SEND;
   always_comb begin
      state_next = state;
      case (state)
         WAIT_A:  state_next = i_rx_done_tick ? WAIT_B : WAIT_A;
         WAIT_B:  state_next = i_rx_done_tick ? WAIT_OP : WAIT_B;
         WAIT_OP: state_next = i_rx_done_tick ? EXEC : WAIT_OP;
         EXEC:    state_next = SEND;
         SEND:    state_next = WAIT_TX;
         WAIT_TX: state_next = i_tx_done_tick ? WAIT_A : WAIT_TX;
         default: state_next = WAIT_A;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state     <= WAIT_A;
         o_alu_a   <= '0;
         o_alu_b   <= '0;
         o_alu_op  <= '0;
         o_tx_data <= '0;
         o_busy    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         state <= state_next;
         if (state == WAIT_A && i_rx_done_tick)
            o_alu_a <= i_rx_data;
         if (state == WAIT_B && i_rx_done_tick)
            o_alu_b <= i_rx_data;
         if (state == WAIT_OP && i_rx_done_tick) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            o_busy   <= 1'b1;
         end
         // ALU inputs settled for a full cycle; sample its output
         if (state == EXEC)
            o_tx_data <= i_alu_result;
         if (state == WAIT_TX && i_tx_done_tick)
            o_busy <= 1'b0;
         if (drop)
            o_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed self-checking bench for uart_alu_interface with a behavioural ALU
module tb_uart_alu_interface;
   import uart_alu_interface_pkg::*;
   logic       clk = 0;
   logic       rst = 0;
   logic       rx_tick = 0;
   logic [7:0] rx_data = 0;
   logic       tx_done = 0;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, overrun;
   int         errors = 0;
   int         checks = 0;
   int         starts = 0;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      logic [5:0] op;
      logic [7:0] res;
   } vec_t;
   vec_t vt[9];

   uart_alu_interface dut (
      .i_clock(clk), .i_reset(rst),
      .i_rx_done_tick(rx_tick), .i_rx_data(rx_data),
      .i_tx_done_tick(tx_done), .i_alu_result(alu_result),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
      .o_tx_start(tx_start), .o_tx_data(tx_data),
      .o_busy(busy), .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_ADD: alu_result = alu_a + alu_b;
         OP_SUB: alu_result = alu_a - alu_b;
         OP_AND: alu_result = alu_a & alu_b;
         OP_OR:  alu_result = alu_a | alu_b;
         OP_XOR: alu_result = alu_a ^ alu_b;
         OP_SRA: alu_result = $signed(alu_a) >>> alu_b;
         OP_SRL: alu_result = alu_a >> alu_b;
         OP_NOR: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
   end

   always @(posedge clk) if (tx_start) starts++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick_rx(input logic [7:0] d);
      @(negedge clk);
      rx_data = d;
      rx_tick = 1;
      @(negedge clk);
      rx_tick = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic finish_tx(input logic [7:0] exp_res);
      idle(3);
      chk("tx_data_held", tx_data, exp_res);
      chk("busy_in_wait_tx", busy, 1);
      @(negedge clk);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      chk("busy_after_done", busy, 0);
   endtask

   // drives A, B, opcode; checks latency up to the tx_start pulse, leaves the FSM in WAIT_TX
   task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                      input logic [5:0] op, input logic [7:0] res);
      int s0;
      tick_rx(a);
      chk("alu_a", alu_a, a);
      idle(1);
      tick_rx(b);
      chk("alu_b", alu_b, b);
      chk("busy_before_op", busy, 0);
      s0 = starts;
      tick_rx(opb);
      chk("alu_op", alu_op, op);
      chk("busy_after_op", busy, 1);
      chk("tx_start_exec", tx_start, 0);
      @(negedge clk);
      chk("tx_start_send", tx_start, 1);
      chk("tx_data", tx_data, res);
      @(negedge clk);
      chk("tx_start_after", tx_start, 0);
      chk("start_count", starts - s0, 1);
   endtask

   initial begin
      vt[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
      vt[1] = '{8'h0F, 8'h3C, 8'hE6, 6'h26, 8'h33};
      vt[2] = '{8'h09, 8'h04, 8'h22, 6'h22, 8'h05};
      vt[3] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
      vt[4] = '{8'h0F, 8'h30, 8'h25, 6'h25, 8'h3F};
      vt[5] = '{8'h0F, 8'h30, 8'h27, 6'h27, 8'hC0};
      vt[6] = '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0};
      vt[7] = '{8'h80, 8'h02, 8'h02, 6'h02, 8'h20};
      vt[8] = '{8'hFF, 8'h01, 8'h60, 6'h20, 8'h00};

      rst = 1;
      idle(2);
      rst = 0;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);

      for (int i = 0; i < 9; i++) begin
         txn(vt[i].a, vt[i].b, vt[i].opb, vt[i].op, vt[i].res);
         finish_tx(vt[i].res);
      end
      chk("no_overrun_clean", overrun, 0);

      // extra byte during WAIT_TX is dropped and flagged
      txn(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
      tick_rx(8'hAA);
      chk("ovr_set", overrun, 1);
      chk("ovr_a_kept", alu_a, 8'h05);
      chk("ovr_busy", busy, 1);
      finish_tx(8'h08);
      txn(8'h01, 8'h01, 8'h22, 6'h22, 8'h00);
      finish_tx(8'h00);
      chk("ovr_sticky", overrun, 1);

      // reset mid-transaction abandons partial operands
      tick_rx(8'h10);
      tick_rx(8'h20);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_rst_a", alu_a, 0);
      chk("mid_rst_b", alu_b, 0);
      chk("mid_rst_ovr", overrun, 0);
      begin
         int sr;
         sr = starts;
         txn(8'h02, 8'h02, 8'h20, 6'h20, 8'h04);
         chk("mid_rst_starts", starts - sr, 1);
      end
      finish_tx(8'h04);

      // spurious tx_done in WAIT_B is ignored
      tick_rx(8'h07);
      @(negedge clk);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      tick_rx(8'h02);
      chk("spur_b", alu_b, 8'h02);
      chk("spur_a", alu_a, 8'h07);
      tick_rx(8'h22);
      chk("spur_busy", busy, 1);
      idle(1);
      chk("spur_start", tx_start, 1);
      chk("spur_res", tx_data, 8'h05);
      finish_tx(8'h05);

      // simultaneous rx_done and tx_done in WAIT_TX
      txn(8'h30, 8'h03, 8'h22, 6'h22, 8'h2D);
      chk("sim_ovr_before", overrun, 0);
      idle(2);
      @(negedge clk);
      rx_data = 8'h55;
      rx_tick = 1;
      tx_done = 1;
      @(negedge clk);
      rx_tick = 0;
      tx_done = 0;
      chk("sim_ovr", overrun, 1);
      chk("sim_busy", busy, 0);
      chk("sim_a_kept", alu_a, 8'h30);
      txn(8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08);
      finish_tx(8'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
